// File: rtl/uart_dbg_pkg.sv
// Shared definitions for the UART debug write path: command/status byte
// codes, AXI4-Lite constants, bus widths and the writer state encoding.
package uart_dbg_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 16;

    localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h57;   // 'W'
    localparam logic [BYTE_W-1:0] ST_OK     = 8'h4B;   // 'K'
    localparam logic [BYTE_W-1:0] ST_ERR    = 8'h45;   // 'E'
    localparam logic [BYTE_W-1:0] ST_BADCMD = 8'h3F;   // '?'

    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [2:0] AXI_PROT  = 3'b000;
    localparam logic [1:0] AXI_STRB  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_A_HI,
        S_A_LO,
        S_D_HI,
        S_D_LO,
        S_WRITE,
        S_RESP,
        S_SEND
    } wr_state_e;

    // True while a frame is partially received (byte collection states).
    function automatic logic is_frame_state(input wr_state_e s);
        return (s == S_A_HI) || (s == S_A_LO) || (s == S_D_HI) || (s == S_D_LO);
    endfunction

endpackage

// File: rtl/uart_axi_writer_if.sv
// Bundle of the writer's byte streams and AXI4-Lite write channels.
//   rx_*  : byte stream from uart_rx       tx_* : status byte to uart_tx
//   aw_*  : write address channel          w_*  : write data channel
//   b_*   : write response channel
// master = the writer, slave = its environment (UART + responder).
interface uart_axi_writer_if;
    import uart_dbg_pkg::*;

    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              aw_valid;
    logic              aw_ready;
    logic [ADDR_W-1:0] aw_addr;
    logic [2:0]        aw_prot;
    logic              w_valid;
    logic              w_ready;
    logic [DATA_W-1:0] w_data;
    logic [1:0]        w_strb;
    logic              b_valid;
    logic              b_ready;
    logic [1:0]        b_resp;

    modport master (
        input  rx_data, rx_valid, tx_ready, aw_ready, w_ready, b_valid, b_resp,
        output rx_ready, tx_data, tx_valid, aw_valid, aw_addr, aw_prot,
               w_valid, w_data, w_strb, b_ready
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, aw_ready, w_ready, b_valid, b_resp,
        input  rx_ready, tx_data, tx_valid, aw_valid, aw_addr, aw_prot,
               w_valid, w_data, w_strb, b_ready
    );

endinterface

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout: down-counter loaded with TIMEOUT on clr, counting while
// en is high; expire_c pulses on the TIMEOUT-th enabled cycle after the load.
//   clk, rst_n : clock, async active-low reset
//   en         : count enable (frame partially received)
//   clr        : reload (byte accepted); has priority over expiry
//   expire_c   : one-cycle expiry pulse (combinational); TIMEOUT = 0 disables
module uart_frame_timer #(
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expire_c
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    // Reload on clear, otherwise count down to zero while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= CNT_W'(TIMEOUT);
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Count 1 marks the last cycle of the window.
    assign expire_c = (TIMEOUT != 0) && en && !clr && (cnt == CNT_W'(1));

endmodule

// File: rtl/uart_axi_writer.sv
// UART-driven AXI4-Lite write initiator. Collects 'W' addr_hi addr_lo
// data_hi data_lo from the rx stream, issues one AW/W/B write and returns a
// status byte ('K', 'E', or '?' for an unknown command) on the tx stream.
//   a_clk, a_rst : clock, async active-low reset
//   bus          : rx/tx byte streams and AXI4-Lite write channels (master)
module uart_axi_writer
    import uart_dbg_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic               a_clk,
    input  logic               a_rst,
    uart_axi_writer_if.master  bus
);

    wr_state_e         state;
    logic              rx_ready_q;
    logic              tx_valid_q;
    logic [BYTE_W-1:0] tx_data_q;
    logic              aw_valid_q;
    logic              w_valid_q;
    logic              b_ready_q;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [DATA_W-1:0] w_data_q;

    logic rx_fire_c;
    logic in_frame_c;
    logic expire_c;
    logic aw_left_c;
    logic w_left_c;

    assign rx_fire_c  = bus.rx_valid & rx_ready_q;
    assign in_frame_c = is_frame_state(state);
    // A channel is still outstanding after this cycle if its valid misses ready.
    assign aw_left_c  = aw_valid_q & ~bus.aw_ready;
    assign w_left_c   = w_valid_q & ~bus.w_ready;

    uart_frame_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (a_clk),
        .rst_n    (a_rst),
        .en       (in_frame_c),
        .clr      (rx_fire_c),
        .expire_c (expire_c)
    );

    // Frame FSM with registered outputs; each transition sets the output
    // values that belong to the target state.
    always_ff @(posedge a_clk or negedge a_rst) begin
        if (!a_rst) begin
            state      <= S_IDLE;
            rx_ready_q <= 1'b1;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_fire_c) begin
                        if (bus.rx_data == CMD_WRITE) begin
                            state <= S_A_HI;
                        end else begin
                            state      <= S_SEND;
                            rx_ready_q <= 1'b0;
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= ST_BADCMD;
                        end
                    end
                end
                S_A_HI: begin
                    if (rx_fire_c) begin
                        // Only 12 address bits exist; the high nibble is dropped.
                        aw_addr_q <= {bus.rx_data[3:0], aw_addr_q[7:0]};
                        state     <= S_A_LO;
                    end else if (expire_c) begin
                        state <= S_IDLE;
                    end
                end
                S_A_LO: begin
                    if (rx_fire_c) begin
                        aw_addr_q <= {aw_addr_q[11:8], bus.rx_data};
                        state     <= S_D_HI;
                    end else if (expire_c) begin
                        state <= S_IDLE;
                    end
                end
                S_D_HI: begin
                    if (rx_fire_c) begin
                        w_data_q <= {bus.rx_data, w_data_q[7:0]};
                        state    <= S_D_LO;
                    end else if (expire_c) begin
                        state <= S_IDLE;
                    end
                end
                S_D_LO: begin
                    if (rx_fire_c) begin
                        w_data_q   <= {w_data_q[15:8], bus.rx_data};
                        state      <= S_WRITE;
                        rx_ready_q <= 1'b0;
                        aw_valid_q <= 1'b1;
                        w_valid_q  <= 1'b1;
                    end else if (expire_c) begin
                        state <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    // AW and W complete independently; a done channel stays low.
                    if (bus.aw_ready) aw_valid_q <= 1'b0;
                    if (bus.w_ready)  w_valid_q  <= 1'b0;
                    if (!aw_left_c && !w_left_c) begin
                        state     <= S_RESP;
                        b_ready_q <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.b_valid) begin
                        state      <= S_SEND;
                        b_ready_q  <= 1'b0;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= (bus.b_resp == RESP_OKAY) ? ST_OK : ST_ERR;
                    end
                end
                S_SEND: begin
                    if (bus.tx_ready) begin
                        state      <= S_IDLE;
                        tx_valid_q <= 1'b0;
                        rx_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rx_ready = rx_ready_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.aw_valid = aw_valid_q;
    assign bus.aw_addr  = aw_addr_q;
    assign bus.aw_prot  = AXI_PROT;
    assign bus.w_valid  = w_valid_q;
    assign bus.w_data   = w_data_q;
    assign bus.w_strb   = AXI_STRB;
    assign bus.b_ready  = b_ready_q;

endmodule

// File: tb/tb_uart_axi_writer.sv
// Scoreboard bench for uart_axi_writer: stimulus pushes expected AW address,
// W data and status bytes; a monitor pops and compares on each handshake.
module tb_uart_axi_writer;

    logic a_clk = 1'b0;
    logic a_rst;

    uart_axi_writer_if bus ();

    uart_axi_writer #(
        .TIMEOUT (16)
    ) dut (
        .a_clk (a_clk),
        .a_rst (a_rst),
        .bus   (bus)
    );

    always #5 a_clk = ~a_clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_aw[$];
    logic [31:0] exp_w[$];
    logic [31:0] exp_tx[$];

    int         aw_delay = 0;
    int         w_delay  = 0;
    logic [1:0] resp     = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got 0x%0h expected nothing", name, act);
    endtask

    // Write responder: AW/W ready after a programmable wait, B after both.
    task automatic responder();
        int aw_wait = 0;
        int w_wait  = 0;
        bit aw_seen = 0;
        bit w_seen  = 0;
        bit b_fire  = 0;
        bus.aw_ready = 1'b0;
        bus.w_ready  = 1'b0;
        bus.b_valid  = 1'b0;
        bus.b_resp   = 2'b00;
        forever begin
            @(negedge a_clk);
            if (!a_rst) begin
                aw_wait = 0; w_wait = 0; aw_seen = 0; w_seen = 0; b_fire = 0;
                bus.aw_ready = 1'b0;
                bus.w_ready  = 1'b0;
                bus.b_valid  = 1'b0;
            end else begin
                if (b_fire) begin
                    bus.b_valid = 1'b0;
                    b_fire = 0;
                end
                if (aw_seen && w_seen && !bus.b_valid) begin
                    bus.b_valid = 1'b1;
                    bus.b_resp  = resp;
                    aw_seen = 0;
                    w_seen  = 0;
                end
                if (bus.b_valid && bus.b_ready) b_fire = 1;
                if (bus.aw_valid) begin
                    if (aw_wait >= aw_delay) begin
                        bus.aw_ready = 1'b1; aw_seen = 1; aw_wait = 0;
                    end else begin
                        bus.aw_ready = 1'b0; aw_wait++;
                    end
                end else begin
                    bus.aw_ready = 1'b0;
                end
                if (bus.w_valid) begin
                    if (w_wait >= w_delay) begin
                        bus.w_ready = 1'b1; w_seen = 1; w_wait = 0;
                    end else begin
                        bus.w_ready = 1'b0; w_wait++;
                    end
                end else begin
                    bus.w_ready = 1'b0;
                end
            end
        end
    endtask

    // Scoreboard monitor: compares every completed handshake against the queues.
    task automatic monitor();
        forever begin
            @(negedge a_clk);
            if (a_rst) begin
                if (bus.aw_valid && bus.aw_ready) begin
                    if (exp_aw.size() == 0) flag("aw_unexpected", 32'(bus.aw_addr));
                    else check("aw_addr", 32'(bus.aw_addr), exp_aw.pop_front());
                    check("aw_prot", 32'(bus.aw_prot), 32'h0);
                end
                if (bus.w_valid && bus.w_ready) begin
                    if (exp_w.size() == 0) flag("w_unexpected", 32'(bus.w_data));
                    else check("w_data", 32'(bus.w_data), exp_w.pop_front());
                    check("w_strb", 32'(bus.w_strb), 32'h3);
                end
                if (bus.tx_valid && bus.tx_ready) begin
                    if (exp_tx.size() == 0) flag("tx_unexpected", 32'(bus.tx_data));
                    else check("tx_data", 32'(bus.tx_data), exp_tx.pop_front());
                end
            end
        end
    endtask

    // Present one byte; returns #1 after the edge on which it was accepted.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge a_clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && n < 200) begin
            @(negedge a_clk);
            n++;
        end
        if (!bus.rx_ready) flag("rx_accept_timeout", 32'(b));
        @(posedge a_clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] ah, input logic [7:0] al,
                              input logic [7:0] dh, input logic [7:0] dl);
        send_byte(8'h57);
        send_byte(ah);
        send_byte(al);
        send_byte(dh);
        send_byte(dl);
    endtask

    // Wait (bounded) for the status byte handshake, then one more cycle.
    task automatic wait_status();
        int n = 0;
        while (!(bus.tx_valid && bus.tx_ready) && n < 200) begin
            @(negedge a_clk);
            n++;
        end
        if (!(bus.tx_valid && bus.tx_ready)) flag("status_timeout", 32'(n));
        @(posedge a_clk);
        #1;
    endtask

    initial begin
        a_rst        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b1;
        fork
            responder();
            monitor();
        join_none

        // Reset values
        repeat (3) @(posedge a_clk);
        #1;
        check("rst_rx_ready", 32'(bus.rx_ready), 32'h1);
        check("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
        check("rst_tx_data",  32'(bus.tx_data),  32'h0);
        check("rst_aw_valid", 32'(bus.aw_valid), 32'h0);
        check("rst_w_valid",  32'(bus.w_valid),  32'h0);
        check("rst_b_ready",  32'(bus.b_ready),  32'h0);
        check("rst_aw_addr",  32'(bus.aw_addr),  32'h0);
        check("rst_w_data",   32'(bus.w_data),   32'h0);
        @(negedge a_clk);
        a_rst = 1'b1;
        @(posedge a_clk);
        #1;

        // Basic write with cycle-exact latency
        exp_aw.push_back(32'h123); exp_w.push_back(32'hBEEF); exp_tx.push_back(32'h4B);
        send_frame(8'h01, 8'h23, 8'hBE, 8'hEF);
        check("n1_aw_valid", 32'(bus.aw_valid), 32'h1);
        check("n1_w_valid",  32'(bus.w_valid),  32'h1);
        check("n1_b_ready",  32'(bus.b_ready),  32'h0);
        check("n1_rx_ready", 32'(bus.rx_ready), 32'h0);
        @(posedge a_clk); #1;
        check("n2_aw_valid", 32'(bus.aw_valid), 32'h0);
        check("n2_w_valid",  32'(bus.w_valid),  32'h0);
        check("n2_b_ready",  32'(bus.b_ready),  32'h1);
        @(posedge a_clk); #1;
        check("n3_tx_valid", 32'(bus.tx_valid), 32'h1);
        check("n3_b_ready",  32'(bus.b_ready),  32'h0);
        wait_status();

        // Upper address nibble ignored, error response
        resp = 2'b10;
        exp_aw.push_back(32'h456); exp_w.push_back(32'h0001); exp_tx.push_back(32'h45);
        send_frame(8'hF4, 8'h56, 8'h00, 8'h01);
        wait_status();
        resp = 2'b00;

        // AW delayed 5 cycles, W immediate
        aw_delay = 5;
        exp_aw.push_back(32'hABC); exp_w.push_back(32'h1234); exp_tx.push_back(32'h4B);
        send_frame(8'h0A, 8'hBC, 8'h12, 8'h34);
        for (int k = 1; k <= 6; k++) begin
            check("dly_aw_valid", 32'(bus.aw_valid), 32'h1);
            check("dly_aw_addr",  32'(bus.aw_addr),  32'hABC);
            check("dly_w_valid",  32'(bus.w_valid),  (k == 1) ? 32'h1 : 32'h0);
            check("dly_b_ready",  32'(bus.b_ready),  32'h0);
            @(posedge a_clk); #1;
        end
        check("dly_aw_drop", 32'(bus.aw_valid), 32'h0);
        check("dly_b_ready_after", 32'(bus.b_ready), 32'h1);
        wait_status();
        aw_delay = 0;

        // Unknown command byte, then a normal frame
        exp_tx.push_back(32'h3F);
        send_byte(8'h41);
        check("bad_tx_valid", 32'(bus.tx_valid), 32'h1);
        check("bad_aw_valid", 32'(bus.aw_valid), 32'h0);
        wait_status();
        exp_aw.push_back(32'h789); exp_w.push_back(32'hCAFE); exp_tx.push_back(32'h4B);
        send_frame(8'h07, 8'h89, 8'hCA, 8'hFE);
        wait_status();

        // Byte 15 cycles after the last one still continues the frame
        exp_aw.push_back(32'h177); exp_w.push_back(32'h8899); exp_tx.push_back(32'h4B);
        send_byte(8'h57);
        send_byte(8'h01);
        repeat (14) @(posedge a_clk);
        send_byte(8'h77);
        send_byte(8'h88);
        send_byte(8'h99);
        wait_status();

        // 16 idle cycles: frame dropped silently, next byte is a command
        send_byte(8'h57);
        send_byte(8'h02);
        repeat (16) @(posedge a_clk);
        exp_tx.push_back(32'h3F);
        send_byte(8'h41);
        wait_status();
        exp_aw.push_back(32'h2A5); exp_w.push_back(32'h5A5A); exp_tx.push_back(32'h4B);
        send_frame(8'h02, 8'hA5, 8'h5A, 8'h5A);
        wait_status();

        // Transmitter stalls for 10 cycles in SEND
        bus.tx_ready = 1'b0;
        exp_aw.push_back(32'h333); exp_w.push_back(32'h4455); exp_tx.push_back(32'h4B);
        send_frame(8'h03, 8'h33, 8'h44, 8'h55);
        begin
            int n = 0;
            while (!bus.tx_valid && n < 50) begin
                @(posedge a_clk); #1;
                n++;
            end
        end
        for (int k = 0; k < 10; k++) begin
            check("stall_tx_valid", 32'(bus.tx_valid), 32'h1);
            check("stall_tx_data",  32'(bus.tx_data),  32'h4B);
            check("stall_rx_ready", 32'(bus.rx_ready), 32'h0);
            @(posedge a_clk); #1;
        end
        bus.tx_ready = 1'b1;
        wait_status();

        // Reset while stuck in WRITE abandons the transaction
        aw_delay = 20;
        w_delay  = 20;
        send_frame(8'h0F, 8'hFF, 8'hDE, 8'hAD);
        @(posedge a_clk); #1;
        check("pre_rst_aw_valid", 32'(bus.aw_valid), 32'h1);
        a_rst = 1'b0;
        #1;
        check("arst_aw_valid", 32'(bus.aw_valid), 32'h0);
        check("arst_w_valid",  32'(bus.w_valid),  32'h0);
        check("arst_b_ready",  32'(bus.b_ready),  32'h0);
        check("arst_tx_valid", 32'(bus.tx_valid), 32'h0);
        check("arst_rx_ready", 32'(bus.rx_ready), 32'h1);
        repeat (2) @(negedge a_clk);
        aw_delay = 0;
        w_delay  = 0;
        a_rst    = 1'b1;
        @(posedge a_clk); #1;
        check("post_rst_rx_ready", 32'(bus.rx_ready), 32'h1);
        exp_aw.push_back(32'h0E1); exp_w.push_back(32'h0F0F); exp_tx.push_back(32'h4B);
        send_frame(8'h30, 8'hE1, 8'h0F, 8'h0F);
        wait_status();

        repeat (4) @(posedge a_clk);
        check("left_aw", 32'(exp_aw.size()), 32'h0);
        check("left_w",  32'(exp_w.size()),  32'h0);
        check("left_tx", 32'(exp_tx.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
